// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU types used by the fetch controller: fetch FSM states and PC step.
package cpu_types;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_FULL  = 2'd2,
        FETCH_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_ctrl_skid_buffer.sv
// One-entry holding register for an instruction that arrived while decode
// was stalled on the instruction already in the output register.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;

    // Next-entry selection: clear wins, then load, then drain.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc_d    = '0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, sequences instruction-memory
// requests, presents one registered instruction per cycle to decode and
// kills wrong-path work on a redirect from the execute-stage jump unit.
module fetch_ctrl
    import cpu_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;

    logic         skid_load, skid_drain, skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_instr, skid_pc;
    logic         consume;

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // Decode takes the output register this cycle.
    assign consume = if_valid_q && !stall;

    // Next-state, PC and output-register update; redirect beats stall everywhere.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        if_valid_d   = if_valid_q && !consume;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
            end

            FETCH_REQ: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    if (!imem_ack) begin
                        // The in-flight request must still complete; remember it.
                        drain_addr_d = pc_q;
                        state_d      = FETCH_DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_incr(pc_q);
                    if (!if_valid_q || !stall) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = FETCH_FULL;
                    end
                end
            end

            FETCH_FULL: begin
                if (redirect) begin
                    skid_clear = 1'b1;
                    if_valid_d = 1'b0;
                    pc_d       = redirect_pc;
                    state_d    = FETCH_REQ;
                end else if (!stall) begin
                    skid_drain = 1'b1;
                    if_valid_d = skid_valid;
                    if_instr_d = skid_instr;
                    if_pc_d    = skid_pc;
                    state_d    = FETCH_REQ;
                end
            end

            FETCH_DRAIN: begin
                if_valid_d = 1'b0;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = FETCH_REQ;
                end
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // Controller state and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
        end
    end

    assign imem_req  = (state_q == FETCH_REQ) || (state_q == FETCH_DRAIN);
    assign imem_addr = (state_q == FETCH_DRAIN) ? drain_addr_q : pc_q;
    assign flush     = redirect;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

endmodule
